// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-cycle enable/flush for IF_ID, ID_EX, EX_MEM, MEM_WB and the PC,
// resolving data wait, fetch miss, load-use, redirect and halt, plus a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int STALL_W = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               dREN_m,
    input  logic               dWEN_m,
    input  logic               halt_m,
    input  logic               dREN_x,
    input  logic [4:0]         wsel_x,
    input  logic [4:0]         rs_d,
    input  logic [4:0]         rt_d,
    input  logic               redirect_x,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               idex_en,
    output logic               exmem_en,
    output logic               memwb_en,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               exmem_flush,
    output logic               memwb_flush,
    output logic               halt,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

    state_t             state_q, state_d;
    logic               halt_q, halt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               dbusy, lduse;

    assign dbusy = (dREN_m | dWEN_m) & ~dhit;
    assign lduse = dREN_x & (wsel_x != 5'd0) & ((wsel_x == rs_d) | (wsel_x == rt_d));

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (state_q != HALTED) begin
            if (dbusy) begin
                state_d = DWAIT;
            end else if (halt_m) begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && state_q != HALTED && stall_cnt_q != {STALL_W{1'b1}})
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end

    // Outputs: priority chain, highest first; flush wins over enable inside the pipe registers.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!nRST || state_q == HALTED || dbusy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (halt_m) begin
            // Let the halt itself retire through MEM_WB, freeze everything upstream.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (redirect_x) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lduse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign halt      = halt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded bench for pipe_hazard_ctrl: expected controls are queued when stimulus is
// driven and compared on the following falling edge; a second instance checks saturation.
module tb_pipe_hazard_ctrl;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
    localparam logic [8:0] C_RUN    = 9'b1_1111_0000;
    localparam logic [8:0] C_FREEZE = 9'b0_0000_0000;
    localparam logic [8:0] C_HRET   = 9'b0_0001_0000;
    localparam logic [8:0] C_REDIR  = 9'b1_1111_1100;
    localparam logic [8:0] C_LDUSE  = 9'b0_0111_0100;
    localparam logic [8:0] C_IMISS  = 9'b0_1111_1000;

    typedef struct {
        string       tag;
        logic [8:0]  ctl;
        logic        halt;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dREN_m, dWEN_m, halt_m, dREN_x, redirect_x;
    logic [4:0]  wsel_x, rs_d, rt_d;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        halt;
    logic [15:0] stall_cnt;
    logic        pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2;
    logic        ifid_flush2, idex_flush2, exmem_flush2, memwb_flush2;
    logic        halt2;
    logic [1:0]  stall_cnt2;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.STALL_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_m(dREN_m), .dWEN_m(dWEN_m),
        .halt_m(halt_m), .dREN_x(dREN_x), .wsel_x(wsel_x), .rs_d(rs_d), .rt_d(rt_d),
        .redirect_x(redirect_x), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.STALL_W(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_m(dREN_m), .dWEN_m(dWEN_m),
        .halt_m(halt_m), .dREN_x(dREN_x), .wsel_x(wsel_x), .rs_d(rs_d), .rt_d(rt_d),
        .redirect_x(redirect_x), .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2),
        .exmem_en(exmem_en2), .memwb_en(memwb_en2), .ifid_flush(ifid_flush2),
        .idex_flush(idex_flush2), .exmem_flush(exmem_flush2), .memwb_flush(memwb_flush2),
        .halt(halt2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic drive(input string tag, input logic rst_n, input logic ih,
                         input logic drm, input logic dwm, input logic dh, input logic hm,
                         input logic drx, input logic [4:0] ws, input logic [4:0] rs,
                         input logic [4:0] rt, input logic rd, input logic [8:0] ctl,
                         input logic hlt, input logic [15:0] cnt);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST = rst_n; ihit = ih; dREN_m = drm; dWEN_m = dwm; dhit = dh; halt_m = hm;
        dREN_x = drx; wsel_x = ws; rs_d = rs; rt_d = rt; redirect_x = rd;
        e.tag  = tag;
        e.ctl  = ctl;
        e.halt = hlt;
        e.cnt  = cnt;
        e.cnt2 = (cnt > 16'd3) ? 2'd3 : cnt[1:0];
        sb_q.push_back(e);
    endtask

    // Compare the oldest expectation against the outputs sampled on the falling edge.
    task automatic compare();
        exp_t e;
        @(negedge CLK);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, "_ctl"}, {23'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush}, {23'd0, e.ctl});
        check({e.tag, "_halt"}, {31'd0, halt}, {31'd0, e.halt});
        check({e.tag, "_cnt"}, {16'd0, stall_cnt}, {16'd0, e.cnt});
        check({e.tag, "_cnt2"}, {30'd0, stall_cnt2}, {30'd0, e.cnt2});
    endtask

    task automatic step(input string tag, input logic rst_n, input logic ih,
                        input logic drm, input logic dwm, input logic dh, input logic hm,
                        input logic drx, input logic [4:0] ws, input logic [4:0] rs,
                        input logic [4:0] rt, input logic rd, input logic [8:0] ctl,
                        input logic hlt, input logic [15:0] cnt);
        drive(tag, rst_n, ih, drm, dwm, dh, hm, drx, ws, rs, rt, rd, ctl, hlt, cnt);
        compare();
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; dREN_m = 1'b0; dWEN_m = 1'b0; halt_m = 1'b0;
        dREN_x = 1'b0; wsel_x = 5'd0; rs_d = 5'd0; rt_d = 5'd0; redirect_x = 1'b0;
        repeat (2) @(posedge CLK);
        //   tag       rst ih drm dwm dh hm drx ws    rs    rt    rd  ctl       halt cnt
        step("reset",   0, 1, 0,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_FREEZE, 0, 16'd0);
        for (int i = 0; i < 4; i++)
            step("run",  1, 1, 0,  0,  0, 0, 0,  5'd3, 5'd1, 5'd2, 0, C_RUN,    0, 16'd0);
        for (int i = 0; i < 3; i++)
            step("dwait", 1, 1, 1, 0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_FREEZE, 0, 16'(i));
        step("dhit",    1, 1, 1,  0,  1, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_RUN,    0, 16'd3);
        step("post_d",  1, 1, 0,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_RUN,    0, 16'd3);
        step("lduse_rs", 1, 1, 0, 0,  0, 0, 1,  5'd8, 5'd8, 5'd1, 0, C_LDUSE,  0, 16'd3);
        step("ld_moved", 1, 1, 0, 0,  0, 0, 0,  5'd8, 5'd8, 5'd1, 0, C_RUN,    0, 16'd4);
        step("ld_r0",   1, 1, 0,  0,  0, 0, 1,  5'd0, 5'd0, 5'd0, 0, C_RUN,    0, 16'd4);
        step("lduse_rt", 1, 1, 0, 0,  0, 0, 1,  5'd5, 5'd1, 5'd5, 0, C_LDUSE,  0, 16'd4);
        step("redir_all", 1, 0, 0, 0, 0, 0, 1,  5'd8, 5'd8, 5'd0, 1, C_REDIR,  0, 16'd5);
        step("imiss",   1, 0, 0,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_IMISS,  0, 16'd5);
        step("ld_imiss", 1, 0, 0, 0,  0, 0, 1,  5'd9, 5'd2, 5'd9, 0, C_LDUSE,  0, 16'd6);
        step("run2",    1, 1, 0,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_RUN,    0, 16'd7);
        for (int i = 0; i < 2; i++)
            step("h_wait", 1, 1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, C_FREEZE, 0, 16'(7 + i));
        step("h_retire", 1, 1, 0, 1,  1, 1, 0,  5'd0, 5'd0, 5'd0, 0, C_HRET,   0, 16'd9);
        step("halted",  1, 1, 0,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_FREEZE, 1, 16'd10);
        step("halted2", 1, 0, 0,  0,  0, 0, 1,  5'd4, 5'd4, 5'd0, 1, C_FREEZE, 1, 16'd10);
        step("rst_halt", 0, 1, 0, 0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_FREEZE, 0, 16'd0);
        step("run3",    1, 1, 0,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_RUN,    0, 16'd0);
        for (int i = 0; i < 5; i++)
            step("sat",  1, 0, 0,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_IMISS,  0, 16'(i));
        step("sat_end", 1, 1, 0,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_RUN,    0, 16'd5);
        // Assert reset mid-wait: outputs and registers drop without a clock edge.
        step("dw_pre",  1, 1, 1,  0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_FREEZE, 0, 16'd5);
        #2;
        nRST = 1'b0;
        #1;
        check("async_rst_ctl", {23'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush}, 32'd0);
        check("async_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        step("dw_after", 1, 1, 0, 0,  0, 0, 0,  5'd0, 5'd0, 5'd0, 0, C_RUN,    0, 16'd0);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
